ibuffer_mw: RTL

- Parametrised multi-width instruction buffer between the I-cache line fetch and the decoder.
- Accepts one fetched line of INST_PER_LINE 32-bit instructions per handshake and writes them into a circular queue in a single cycle. Leading slots before an unaligned entry PC are skipped.
- Presents up to DEQ_WIDTH oldest instructions, each with its PC, to decode every cycle.
- Issues single-cycle line-refill requests from an occupancy threshold, and supports a one-cycle flush.

---
 rtl/ibuffer_pkg.sv | 22 ++
 rtl/ibuffer_refill_fsm.sv | 51 +++++
 rtl/ibuffer_mw.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ibuffer_pkg.sv
// Shared types and helpers for the multi-width instruction buffer.
// Holds the instruction width, default entry layout and port width helper.
package ibuffer_pkg;

  localparam int INST_WIDTH = 32;
  localparam int PC_WIDTH_DEF = 48;

  typedef struct packed {
    logic [INST_WIDTH-1:0]   inst;
    logic [PC_WIDTH_DEF-1:0] pc;
  } entry_t;

  typedef enum logic {
    RF_IDLE = 1'b0,
    RF_WAIT = 1'b1
  } refill_state_t;

  function automatic int acc_width(input int deq_width);
    return $clog2(deq_width + 1);
  endfunction

endpackage

// File: rtl/ibuffer_refill_fsm.sv
// Refill request state machine: one fetch_req pulse per outstanding line.
// Ports: clock, reset, count, fetch_allowed, fire, flush -> fetch_req.
module ibuffer_refill_fsm
  import ibuffer_pkg::*;
#(
  parameter int CNT_W         = 6,
  parameter int REFILL_THRESH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] count,
  input  logic             fetch_allowed,
  input  logic             fire,
  input  logic             flush,
  output logic             fetch_req
);

  refill_state_t state;
  refill_state_t state_nxt;
  logic          req_nxt;
  logic          low;

  assign low = count <= CNT_W'(REFILL_THRESH);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RF_IDLE;
      fetch_req <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_req <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = 1'b0;
    unique case (state)
      RF_IDLE: begin
        if (fetch_allowed && low && !flush) begin
          state_nxt = RF_WAIT;
          req_nxt   = 1'b1;
        end
      end
      RF_WAIT: begin
        if (fire || flush) state_nxt = RF_IDLE;
      end
    endcase
  end

endmodule

// File: rtl/ibuffer_mw.sv
// Multi-width instruction buffer: line-wide enqueue, DEQ_WIDTH-wide dequeue.
// Ports: line_* fetch side, deq_* decode side, fetch_req refill, flush, count.
module ibuffer_mw
  import ibuffer_pkg::*;
#(
  parameter int INST_PER_LINE = 16,
  parameter int PC_WIDTH      = 48,
  parameter int DEPTH         = 32,
  parameter int DEQ_WIDTH     = 2,
  parameter int REFILL_THRESH = 4
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                line_valid,
  output logic                                line_ready,
  input  logic [INST_PER_LINE*INST_WIDTH-1:0] line_data,
  input  logic [PC_WIDTH-1:0]                 line_pc,
  input  logic [$clog2(INST_PER_LINE)-1:0]    line_start_idx,
  input  logic                                fetch_allowed,
  output logic                                fetch_req,
  output logic [DEQ_WIDTH-1:0]                deq_valid,
  output logic [DEQ_WIDTH*INST_WIDTH-1:0]     deq_inst,
  output logic [DEQ_WIDTH*PC_WIDTH-1:0]       deq_pc,
  input  logic [acc_width(DEQ_WIDTH)-1:0]     deq_accept,
  input  logic                                flush,
  output logic [$clog2(DEPTH+1)-1:0]          count,
  output logic                                empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(INST_PER_LINE);
  localparam int ACC_W = acc_width(DEQ_WIDTH);

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [PC_WIDTH-1:0]   pc;
  } ent_t;

  ent_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] space;
  logic [IDX_W:0]   enq_n;
  logic [ACC_W-1:0] n_valid;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count_nxt;
  logic             fire;

  // Space check uses the registered count only, so a
  // same-cycle dequeue never lets a line in early.
  assign space      = CNT_W'(DEPTH) - count;
  assign line_ready = !flush && (space >= CNT_W'(INST_PER_LINE));
  assign fire       = line_valid && line_ready;
  assign enq_n      = (IDX_W+1)'(INST_PER_LINE) - (IDX_W+1)'(line_start_idx);
  assign empty      = count == '0;

  // Over-accept is illegal; clamp to what is actually valid.
  assign n_valid = (count >= CNT_W'(DEQ_WIDTH)) ? ACC_W'(DEQ_WIDTH)
                                               : ACC_W'(count);
  assign acc     = (deq_accept > n_valid) ? n_valid : deq_accept;

  assign count_nxt = count
                   + (fire ? CNT_W'(enq_n) : '0)
                   - CNT_W'(acc);

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= fire ? wr_ptr + PTR_W'(enq_n) : wr_ptr;
      rd_ptr <= rd_ptr + PTR_W'(acc);
      count  <= count_nxt;
    end
  end

  // Slot k lands at wr_ptr + (k - start); skipped slots are not written.
  always_ff @(posedge clock) begin
    if (fire) begin
      for (int k = 0; k < INST_PER_LINE; k++) begin
        if (k >= int'(line_start_idx)) begin
          mem[wr_ptr + PTR_W'(k) - PTR_W'(line_start_idx)] <= '{
            inst: line_data[k*INST_WIDTH +: INST_WIDTH],
            pc:   line_pc + PC_WIDTH'(4 * k)
          };
        end
      end
    end
  end

  for (genvar i = 0; i < DEQ_WIDTH; i++) begin : g_deq
    logic [PTR_W-1:0] idx;
    assign idx = rd_ptr + PTR_W'(i);
    assign deq_valid[i] = count > CNT_W'(i);
    assign deq_inst[i*INST_WIDTH +: INST_WIDTH] = mem[idx].inst;
    assign deq_pc[i*PC_WIDTH +: PC_WIDTH] = mem[idx].pc;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      assert (deq_accept <= n_valid);
    end
  end

  ibuffer_refill_fsm #(
    .CNT_W         (CNT_W),
    .REFILL_THRESH (REFILL_THRESH)
  ) u_refill (
    .clock         (clock),
    .reset         (reset),
    .count         (count),
    .fetch_allowed (fetch_allowed),
    .fire          (fire),
    .flush         (flush),
    .fetch_req     (fetch_req)
  );

endmodule
